// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the coprocessor word-memory arbiter: FSM states,
// reserved addresses and requester indices.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RWAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned CONFIG_ADDR     = 0;
  localparam int unsigned STATUS_ADDR     = 1;
  localparam int unsigned PROTECTED_LIMIT = 2;

  localparam int REQ_HOST = 0;
  localparam int REQ_CORE = 1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way grant logic with a one-hot grant output.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Index of the last granted requester; reset to the core so the host goes first.
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_q <= gnt[REQ_CORE];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else if (req[REQ_HOST]) begin
      gnt = 2'b01;
    end else if (req[REQ_CORE]) begin
      gnt = 2'b10;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = clk ^ rst ^ update;

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_HOST]) begin
      gnt = 2'b01;
    end else if (req[REQ_CORE]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester block access controller for the coprocessor word memory.
// Arbitration policy is selected by MEM_ARB_ROUND_ROBIN_EN (see rr_arbiter).
//   state   | meaning
//   IDLE    | waiting for a request, grant and legality check
//   ACCESS  | one-cycle memory read/write strobe
//   RWAIT   | memory read data captured into the winner's rdata
//   DONE    | done pulse to the winner
//   ERR     | done + err pulse, memory untouched
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int SIZE       = 1024,
  parameter int LOG_SIZE   = 10,
  parameter int BLOCKS     = 4,
  parameter int CELL_WIDTH = 32,
  parameter int WIDTH      = BLOCKS * CELL_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_req0,
  input  logic                  in_req1,
  input  logic                  in_we0,
  input  logic                  in_we1,
  input  logic [LOG_SIZE-1:0]   in_addr0,
  input  logic [LOG_SIZE-1:0]   in_addr1,
  input  logic [WIDTH-1:0]      in_wdata0,
  input  logic [WIDTH-1:0]      in_wdata1,
  output logic                  out_done0,
  output logic                  out_done1,
  output logic                  out_err0,
  output logic                  out_err1,
  output logic [WIDTH-1:0]      out_rdata0,
  output logic [WIDTH-1:0]      out_rdata1,
  input  logic                  in_status_req,
  input  logic [CELL_WIDTH-1:0] in_status,
  output logic                  out_status_done,
  output logic [LOG_SIZE-1:0]   out_mem_address,
  output logic [WIDTH-1:0]      out_mem_data,
  output logic                  out_mem_read_en,
  output logic                  out_mem_write_en,
  output logic                  out_mem_write_status_en,
  output logic [CELL_WIDTH-1:0] out_mem_status,
  input  logic [WIDTH-1:0]      in_mem_data,
  output logic                  out_busy
);

  state_t state_q, state_d;

  logic [1:0]          gnt;
  logic                req_any, take, win;
  logic                sel_q, sel_d, we_q;
  logic                pick_we;
  logic [LOG_SIZE-1:0] pick_addr;
  logic [WIDTH-1:0]    pick_wdata;
  logic [LOG_SIZE:0]   end_addr;
  logic                range_bad, prot_bad, fin;
  logic                wr_low_next, status_fire;

  rr_arbiter u_arb (
    .clk    (in_clk),
    .rst    (in_reset),
    .req    ({in_req1, in_req0}),
    .update (take),
    .gnt    (gnt)
  );

  assign req_any    = in_req0 | in_req1;
  assign take       = (state_q == ST_IDLE) && req_any;
  assign win        = gnt[REQ_CORE];
  assign pick_we    = win ? in_we1 : in_we0;
  assign pick_addr  = win ? in_addr1 : in_addr0;
  assign pick_wdata = win ? in_wdata1 : in_wdata0;

  // One extra bit so a block near the top of memory cannot wrap to a small end address.
  assign end_addr  = {1'b0, pick_addr} + (LOG_SIZE+1)'(BLOCKS);
  assign range_bad = end_addr > (LOG_SIZE+1)'(SIZE);
  assign prot_bad  = win && pick_we && (pick_addr < LOG_SIZE'(PROTECTED_LIMIT));

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_any) state_d = (range_bad || prot_bad) ? ST_ERR : ST_ACCESS;
      ST_ACCESS: state_d = we_q ? ST_DONE : ST_RWAIT;
      ST_RWAIT:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign sel_d = (state_q == ST_IDLE) ? win : sel_q;
  assign fin   = (state_d == ST_DONE) || (state_d == ST_ERR);

  // A block write over config/status next cycle pushes the status write one cycle later.
  assign wr_low_next = take && (state_d == ST_ACCESS) && pick_we &&
                       (pick_addr < LOG_SIZE'(PROTECTED_LIMIT));
  assign status_fire = in_status_req && !out_status_done && !wr_low_next;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      sel_q                   <= 1'b0;
      we_q                    <= 1'b0;
      out_mem_address         <= '0;
      out_mem_data            <= '0;
      out_mem_read_en         <= 1'b0;
      out_mem_write_en        <= 1'b0;
      out_done0               <= 1'b0;
      out_done1               <= 1'b0;
      out_err0                <= 1'b0;
      out_err1                <= 1'b0;
      out_rdata0              <= '0;
      out_rdata1              <= '0;
      out_mem_write_status_en <= 1'b0;
      out_status_done         <= 1'b0;
      out_mem_status          <= '0;
    end else begin
      if (take) begin
        sel_q           <= win;
        we_q            <= pick_we;
        out_mem_address <= pick_addr;
        out_mem_data    <= pick_wdata;
      end
      out_mem_write_en <= (state_d == ST_ACCESS) && pick_we;
      out_mem_read_en  <= (state_d == ST_ACCESS) && !pick_we;
      out_done0        <= fin && !sel_d;
      out_done1        <= fin && sel_d;
      out_err0         <= (state_d == ST_ERR) && !sel_d;
      out_err1         <= (state_d == ST_ERR) && sel_d;
      if (state_q == ST_RWAIT) begin
        if (sel_q) begin
          out_rdata1 <= in_mem_data;
        end else begin
          out_rdata0 <= in_mem_data;
        end
      end
      out_mem_write_status_en <= status_fire;
      out_status_done         <= status_fire;
      if (status_fire) begin
        out_mem_status <= in_status;
      end
    end
  end

  assign out_busy = (state_q != ST_IDLE);

endmodule
